// File: rtl/cpu_bp_pkg.sv
// ============================================================================
// Module      : cpu_bp_pkg
// Description : Shared encodings for the gshare direction predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_bp_pkg;

    localparam logic [1:0] c_CTR_SNT  = 2'b00;
    localparam logic [1:0] c_CTR_WNT  = 2'b01;
    localparam logic [1:0] c_CTR_WT   = 2'b10;
    localparam logic [1:0] c_CTR_ST   = 2'b11;
    localparam logic [1:0] c_PHT_INIT = c_CTR_WNT;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != c_CTR_ST) res = ctr + 2'd1;
        end else begin
            if (ctr != c_CTR_SNT) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_gshare_direction_predictor_if.sv
// ============================================================================
// Module      : cpu_gshare_direction_predictor_if
// Description : Fetch/prediction and resolve/training signals of the predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_gshare_direction_predictor_if #(
    parameter int XLEN       = 32,
    parameter int HIST_WIDTH = 8
);
    logic [XLEN-1:0]       fetch_pc;
    logic                  fetch_valid;
    logic                  btb_hit;
    logic [XLEN-1:0]       btb_target;
    logic                  ready;
    logic                  pred_taken;
    logic [XLEN-1:0]       pred_next_pc;
    logic [HIST_WIDTH-1:0] pred_ghr;
    logic                  upd_valid;
    logic [XLEN-1:0]       upd_pc;
    logic [HIST_WIDTH-1:0] upd_ghr;
    logic                  upd_taken;
    logic                  upd_mispredict;

    modport master (
        output fetch_pc, fetch_valid, btb_hit, btb_target,
        output upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
        input  ready, pred_taken, pred_next_pc, pred_ghr
    );

    modport slave (
        input  fetch_pc, fetch_valid, btb_hit, btb_target,
        input  upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
        output ready, pred_taken, pred_next_pc, pred_ghr
    );
endinterface

`default_nettype wire

// File: rtl/cpu_pattern_history_table.sv
// ============================================================================
// Module      : cpu_pattern_history_table
// Description : 2-bit counter array with async read, saturating write and init sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_pattern_history_table
    import cpu_bp_pkg::*;
#(
    parameter int HIST_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  init_i,
    input  wire logic [HIST_WIDTH-1:0] rd_idx_i,
    output logic      [1:0]            rd_ctr_o,
    input  wire logic                  upd_en_i,
    input  wire logic [HIST_WIDTH-1:0] upd_idx_i,
    input  wire logic                  upd_taken_i,
    output logic                       sweep_last_o
);
    localparam int c_DEPTH = 1 << HIST_WIDTH;

    logic [1:0]            pht_q [c_DEPTH];
    logic [HIST_WIDTH-1:0] ptr_q;

    // Read returns the pre-write value; same-cycle updates land at the next edge.
    assign rd_ctr_o     = pht_q[rd_idx_i];
    assign sweep_last_o = init_i & (ptr_q == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (init_i) begin
            ptr_q <= ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (init_i) begin
                pht_q[ptr_q] <= c_PHT_INIT;
            end else if (upd_en_i) begin
                pht_q[upd_idx_i] <= sat_update(pht_q[upd_idx_i], upd_taken_i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_gshare_direction_predictor.sv
// ============================================================================
// Module      : cpu_gshare_direction_predictor
// Description : Gshare direction predictor with speculative GHR and recovery.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_gshare_direction_predictor
    import cpu_bp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BYTE_OFFSET = 2,
    parameter int HIST_WIDTH  = 8
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    cpu_gshare_direction_predictor_if.slave bp
);
    bp_state_e             state_q, state_d;
    logic [HIST_WIDTH-1:0] ghr_q, ghr_d;
    logic                  w_run;
    logic [HIST_WIDTH-1:0] w_fetch_idx;
    logic [HIST_WIDTH-1:0] w_upd_idx;
    logic [1:0]            w_rd_ctr;
    logic                  w_sweep_last;
    logic                  w_pred_taken;
    logic                  w_unused_upd_pc;

    assign w_run       = (state_q == ST_RUN);
    assign w_fetch_idx = bp.fetch_pc[BYTE_OFFSET +: HIST_WIDTH] ^ ghr_q;
    assign w_upd_idx   = bp.upd_pc[BYTE_OFFSET +: HIST_WIDTH] ^ bp.upd_ghr;
    assign w_unused_upd_pc = ^bp.upd_pc;

    cpu_pattern_history_table #(
        .HIST_WIDTH (HIST_WIDTH)
    ) u_pht (
        .clk          (clk),
        .rst          (rst),
        .init_i       (~w_run),
        .rd_idx_i     (w_fetch_idx),
        .rd_ctr_o     (w_rd_ctr),
        .upd_en_i     (w_run & bp.upd_valid),
        .upd_idx_i    (w_upd_idx),
        .upd_taken_i  (bp.upd_taken),
        .sweep_last_o (w_sweep_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (w_sweep_last) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    assign w_pred_taken    = w_run & bp.btb_hit & w_rd_ctr[1];
    assign bp.ready        = w_run;
    assign bp.pred_taken   = w_pred_taken;
    assign bp.pred_next_pc = w_pred_taken ? bp.btb_target : (bp.fetch_pc + XLEN'(4));
    assign bp.pred_ghr     = ghr_q;

    // Misprediction recovery takes priority over the speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (w_run) begin
            if (bp.upd_valid && bp.upd_mispredict) begin
                ghr_d = {bp.upd_ghr[HIST_WIDTH-2:0], bp.upd_taken};
            end else if (bp.fetch_valid && bp.btb_hit) begin
                ghr_d = {ghr_q[HIST_WIDTH-2:0], w_pred_taken};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            ghr_q   <= ghr_d;
        end
    end

endmodule

`default_nettype wire
